reg_file: RTL and testbench

// - Dual-bank register file for the vector ASIP datapath: registerQuantity vector regs + registerQuantity scalar regs.
// - Two combinational read ports feed the ALU operands; one synchronous write port fed from writeback.
// - Scalar reads are broadcast to every lane so scalar/vector ops share one operand format.

---
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Dual-bank register file: vector bank plus scalar bank, two combinational read
// ports and one synchronous writeback port. Scalar reads are broadcast to every lane.
module reg_file #(
  parameter int registerSize     = 8,
  parameter int registerQuantity = 4,
  parameter int selectionBits    = 2,
  parameter int vectorSize       = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     regWrEnSc,
  input  logic                                     regWrEnVec,
  input  logic [selectionBits:0]                   rSel1,
  input  logic [selectionBits:0]                   rSel2,
  input  logic [selectionBits:0]                   regToWrite,
  input  logic [vectorSize-1:0][registerSize-1:0]  dataIn,
  output logic [vectorSize-1:0][registerSize-1:0]  operand1,
  output logic [vectorSize-1:0][registerSize-1:0]  operand2
);

  logic [vectorSize-1:0][registerSize-1:0] vreg_r [registerQuantity];
  logic [registerSize-1:0]                 sreg_r [registerQuantity];
  logic [selectionBits-1:0]                wrIdx_s;
  logic                                    unusedWrMsb_s;

  // The write index ignores the bank bit; the enables pick the bank instead.
  assign wrIdx_s       = regToWrite[selectionBits-1:0];
  assign unusedWrMsb_s = regToWrite[selectionBits];

  // Vector bank storage: async clear, whole-register writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < registerQuantity; i++) begin
        vreg_r[i] <= '0;
      end
    end else if (regWrEnVec) begin
      vreg_r[wrIdx_s] <= dataIn;
    end else begin
      vreg_r[wrIdx_s] <= vreg_r[wrIdx_s];
    end
  end

  // Scalar bank storage: async clear, lane 0 of the write data only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < registerQuantity; i++) begin
        sreg_r[i] <= '0;
      end
    end else if (regWrEnSc) begin
      sreg_r[wrIdx_s] <= dataIn[0];
    end else begin
      sreg_r[wrIdx_s] <= sreg_r[wrIdx_s];
    end
  end

  // Read port 1 decode; no bypass, so a same-cycle write shows only after the edge.
  always_comb begin
    operand1 = '0;
    case (rSel1[selectionBits])
      1'b1:    operand1 = {vectorSize{sreg_r[rSel1[selectionBits-1:0]]}};
      1'b0:    operand1 = vreg_r[rSel1[selectionBits-1:0]];
      default: operand1 = '0;
    endcase
  end

  // Read port 2 decode, independent of port 1.
  always_comb begin
    operand2 = '0;
    case (rSel2[selectionBits])
      1'b1:    operand2 = {vectorSize{sreg_r[rSel2[selectionBits-1:0]]}};
      1'b0:    operand2 = vreg_r[rSel2[selectionBits-1:0]];
      default: operand2 = '0;
    endcase
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: one task per scenario, hand-computed
// expected values, inline comparisons.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        regWrEnSc;
  logic        regWrEnVec;
  logic [2:0]  rSel1;
  logic [2:0]  rSel2;
  logic [2:0]  regToWrite;
  logic [3:0][7:0] dataIn;
  logic [3:0][7:0] operand1;
  logic [3:0][7:0] operand2;

  int vectors;
  int miscompares;

  reg_file dut (
    .clk        (clk),
    .reset      (reset),
    .regWrEnSc  (regWrEnSc),
    .regWrEnVec (regWrEnVec),
    .rSel1      (rSel1),
    .rSel2      (rSel2),
    .regToWrite (regToWrite),
    .dataIn     (dataIn),
    .operand1   (operand1),
    .operand2   (operand2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; regWrEnSc = 1'b0; regWrEnVec = 1'b0;
    rSel1 = 3'd0; rSel2 = 3'd0; regToWrite = 3'd0; dataIn = 32'h0;
    tick();
    reset = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) begin
      rSel1 = 3'(s);
      rSel2 = 3'(7 - s);
      #1;
      vectors++;
      if (operand1 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_p1 sel=%0d got=%h exp=%h", s, operand1, 32'h0);
      end
      vectors++;
      if (operand2 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_p2 sel=%0d got=%h exp=%h", 7 - s, operand2, 32'h0);
      end
    end
  endtask

  task automatic test_scalar_write();
    regWrEnSc = 1'b1; regWrEnVec = 1'b0; regToWrite = 3'd0; dataIn = 32'h00000004;
    rSel1 = 3'd4;
    #1;
    vectors++;
    if (operand1 !== 32'h0) begin
      miscompares++;
      $display("FAIL sc_no_bypass got=%h exp=%h", operand1, 32'h0);
    end
    tick();
    regWrEnSc = 1'b0;
    rSel1 = 3'd4; rSel2 = 3'd1;
    #1;
    vectors++;
    if (operand1 !== 32'h04040404) begin
      miscompares++;
      $display("FAIL sc_bcast got=%h exp=%h", operand1, 32'h04040404);
    end
    vectors++;
    if (operand2 !== 32'h0) begin
      miscompares++;
      $display("FAIL sc_other got=%h exp=%h", operand2, 32'h0);
    end
    rSel1 = 3'd0;
    #1;
    vectors++;
    if (operand1 !== 32'h0) begin
      miscompares++;
      $display("FAIL sc_vreg0 got=%h exp=%h", operand1, 32'h0);
    end
  endtask

  task automatic test_vector_write();
    regWrEnVec = 1'b1; regWrEnSc = 1'b0; regToWrite = 3'd3; dataIn = 32'hDEADBEEF;
    rSel1 = 3'd3;
    #1;
    vectors++;
    if (operand1 !== 32'h0) begin
      miscompares++;
      $display("FAIL vec_no_bypass got=%h exp=%h", operand1, 32'h0);
    end
    tick();
    regWrEnVec = 1'b0;
    #1;
    vectors++;
    if (operand1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL vec_read got=%h exp=%h", operand1, 32'hDEADBEEF);
    end
    rSel1 = 3'd7;
    #1;
    vectors++;
    if (operand1 !== 32'h0) begin
      miscompares++;
      $display("FAIL vec_sreg3 got=%h exp=%h", operand1, 32'h0);
    end
  endtask

  task automatic test_dual_read();
    rSel1 = 3'd4; rSel2 = 3'd3;
    #1;
    vectors++;
    if (operand1 !== 32'h04040404) begin
      miscompares++;
      $display("FAIL dual_p1 got=%h exp=%h", operand1, 32'h04040404);
    end
    vectors++;
    if (operand2 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL dual_p2 got=%h exp=%h", operand2, 32'hDEADBEEF);
    end
  endtask

  task automatic test_lane_mask();
    regWrEnSc = 1'b1; regWrEnVec = 1'b0; regToWrite = 3'd2; dataIn = 32'h11223344;
    tick();
    regWrEnSc = 1'b0;
    rSel1 = 3'd6; rSel2 = 3'd2;
    #1;
    vectors++;
    if (operand1 !== 32'h44444444) begin
      miscompares++;
      $display("FAIL lane_mask got=%h exp=%h", operand1, 32'h44444444);
    end
    vectors++;
    if (operand2 !== 32'h0) begin
      miscompares++;
      $display("FAIL lane_vreg2 got=%h exp=%h", operand2, 32'h0);
    end
  endtask

  task automatic test_both_enables();
    // Index MSB set: must be ignored, so both banks land at index 1.
    regWrEnSc = 1'b1; regWrEnVec = 1'b1; regToWrite = 3'b101; dataIn = 32'hA1B2C3D4;
    tick();
    regWrEnSc = 1'b0; regWrEnVec = 1'b0;
    rSel1 = 3'd1; rSel2 = 3'd5;
    #1;
    vectors++;
    if (operand1 !== 32'hA1B2C3D4) begin
      miscompares++;
      $display("FAIL both_vreg1 got=%h exp=%h", operand1, 32'hA1B2C3D4);
    end
    vectors++;
    if (operand2 !== 32'hD4D4D4D4) begin
      miscompares++;
      $display("FAIL both_sreg1 got=%h exp=%h", operand2, 32'hD4D4D4D4);
    end
    dataIn = 32'h55555555; regToWrite = 3'd1;
    tick();
    #1;
    vectors++;
    if (operand1 !== 32'hA1B2C3D4) begin
      miscompares++;
      $display("FAIL idle_vreg1 got=%h exp=%h", operand1, 32'hA1B2C3D4);
    end
    vectors++;
    if (operand2 !== 32'hD4D4D4D4) begin
      miscompares++;
      $display("FAIL idle_sreg1 got=%h exp=%h", operand2, 32'hD4D4D4D4);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rSel1 = 3'd3; rSel2 = 3'd6;
    #1;
    vectors++;
    if (operand1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL pre_rst got=%h exp=%h", operand1, 32'hDEADBEEF);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (operand1 !== 32'h0) begin
      miscompares++;
      $display("FAIL async_rst got=%h exp=%h", operand1, 32'h0);
    end
    regWrEnVec = 1'b1; regWrEnSc = 1'b1; regToWrite = 3'd3; dataIn = 32'hCAFEF00D;
    tick();
    tick();
    regWrEnVec = 1'b0; regWrEnSc = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (operand1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_wr_vec got=%h exp=%h", operand1, 32'h0);
    end
    rSel2 = 3'd7;
    #1;
    vectors++;
    if (operand2 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_wr_sc got=%h exp=%h", operand2, 32'h0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_scalar_write();
    test_vector_write();
    test_dual_read();
    test_lane_mask();
    test_both_enables();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
